// File: rtl/ntt_writeback.sv
// ntt_writeback
// -----------------------------------------------------------------------------
// Write-back stage that sits directly after the compact butterfly unit of the
// mixed-radix 512-point NTT. Each accepted issue carries its two bank read
// addresses down a delay line. The delay line matches the butterfly latency
// for the issue's radix mode. When the results arrive, the stage registers
// one in-place write per bank. It also counts writes per stage, pulses
// stage_done on the last write of a stage, and holds off mode-switching
// issues until the pipe is empty.
//
// Handshake: an issue transfers on a rising clk edge where in_valid and
// in_ready are both high. in_ready is combinational from inflight, mode and
// in_sel. The issuer may change in_sel while waiting, and in_ready tracks it
// in the same cycle.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid / in_ready       issue handshake
//   in_sel                    0 = two radix-2 butterflies, 1 = radix-4
//   in_addr0 / in_addr1       bank word addresses read for this issue
//   bf_0_upper .. bf_1_lower  butterfly result coefficients
//   we                        write strobe for both banks
//   waddr0 / waddr1           write addresses
//   wdata0 / wdata1           {bf_x_upper, bf_x_lower}
//   stage_done                one-cycle pulse with the PAIRS-th write of a stage
//   busy                      at least one issue is in flight
// -----------------------------------------------------------------------------
module ntt_writeback #(
    parameter int DATA_WIDTH = 12,
    parameter int ADDR_WIDTH = 7,
    parameter int LAT0       = 3,
    parameter int LAT1       = 6,
    parameter int PAIRS      = 128
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_sel,
    input  logic [ADDR_WIDTH-1:0]   in_addr0,
    input  logic [ADDR_WIDTH-1:0]   in_addr1,
    input  logic [DATA_WIDTH-1:0]   bf_0_upper,
    input  logic [DATA_WIDTH-1:0]   bf_0_lower,
    input  logic [DATA_WIDTH-1:0]   bf_1_upper,
    input  logic [DATA_WIDTH-1:0]   bf_1_lower,
    output logic                    we,
    output logic [ADDR_WIDTH-1:0]   waddr0,
    output logic [ADDR_WIDTH-1:0]   waddr1,
    output logic [2*DATA_WIDTH-1:0] wdata0,
    output logic [2*DATA_WIDTH-1:0] wdata1,
    output logic                    stage_done,
    output logic                    busy
);

    localparam int CW = $clog2(LAT1 + 1);
    localparam int WW = $clog2(PAIRS);
    localparam logic [WW-1:0] WCNT_LAST = WW'(PAIRS - 1);

    // Delay line: slot 0 holds the issue accepted on the previous edge.
    logic [LAT1-1:0]       pv;
    logic [LAT1-1:0]       ps;
    logic [ADDR_WIDTH-1:0] pa0 [LAT1];
    logic [ADDR_WIDTH-1:0] pa1 [LAT1];

    logic          mode;
    logic [CW-1:0] inflight;
    logic [WW-1:0] wcnt;

    logic                  accept;
    logic                  ret0;
    logic                  ret1;
    logic                  retire;
    logic [ADDR_WIDTH-1:0] ret_addr0;
    logic [ADDR_WIDTH-1:0] ret_addr1;

    // A mode change is only admitted once every older issue has retired, so
    // the two retire taps can never fire in the same cycle.
    assign in_ready = (inflight == '0) | (in_sel == mode);
    assign busy     = (inflight != '0);
    assign accept   = in_valid & in_ready;

    assign ret0   = pv[LAT0-1] & ~ps[LAT0-1];
    assign ret1   = pv[LAT1-1] &  ps[LAT1-1];
    assign retire = ret0 | ret1;

    assign ret_addr0 = ret1 ? pa0[LAT1-1] : pa0[LAT0-1];
    assign ret_addr1 = ret1 ? pa1[LAT1-1] : pa1[LAT0-1];

    // Delay line shift; a radix-2 entry is dropped as it leaves its tap so it
    // cannot retire a second time at the radix-4 tap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pv <= '0;
            ps <= '0;
            for (int i = 0; i < LAT1; i++) begin
                pa0[i] <= '0;
                pa1[i] <= '0;
            end
        end else begin
            pv[0]  <= accept;
            ps[0]  <= in_sel;
            pa0[0] <= in_addr0;
            pa1[0] <= in_addr1;
            for (int i = 1; i < LAT1; i++) begin
                if (i == LAT0) begin
                    pv[i] <= pv[i-1] & ps[i-1];
                end else begin
                    pv[i] <= pv[i-1];
                end
                ps[i]  <= ps[i-1];
                pa0[i] <= pa0[i-1];
                pa1[i] <= pa1[i-1];
            end
        end
    end

    // Mode and in-flight bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode     <= 1'b0;
            inflight <= '0;
        end else begin
            if (accept) begin
                mode <= in_sel;
            end
            case ({accept, retire})
                2'b10:   inflight <= inflight + CW'(1);
                2'b01:   inflight <= inflight - CW'(1);
                default: inflight <= inflight;
            endcase
        end
    end

    // Write port and stage counter, all registered on the retire edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we         <= 1'b0;
            stage_done <= 1'b0;
            waddr0     <= '0;
            waddr1     <= '0;
            wdata0     <= '0;
            wdata1     <= '0;
            wcnt       <= '0;
        end else begin
            we         <= retire;
            stage_done <= 1'b0;
            if (retire) begin
                waddr0 <= ret_addr0;
                waddr1 <= ret_addr1;
                wdata0 <= {bf_0_upper, bf_0_lower};
                wdata1 <= {bf_1_upper, bf_1_lower};
                if (wcnt == WCNT_LAST) begin
                    wcnt       <= '0;
                    stage_done <= 1'b1;
                end else begin
                    wcnt <= wcnt + WW'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_ntt_writeback.sv
// tb_ntt_writeback
// -----------------------------------------------------------------------------
// Self-checking bench for ntt_writeback. The reference model is a queue of
// expected writes. Each accepted issue is turned into one expected write that
// is due at edge (accept edge + latency of its mode). The write carries that
// issue's addresses and the butterfly values driven just before the due edge.
// Butterfly values come from a pre-rolled random table indexed by edge number.
// A negedge monitor pops and compares every write. It also checks in_ready
// and busy against the model's notion of outstanding work.
// -----------------------------------------------------------------------------
module tb_ntt_writeback;

    localparam int DW    = 12;
    localparam int AW    = 7;
    localparam int LAT0  = 3;
    localparam int LAT1  = 6;
    localparam int PAIRS = 128;
    localparam int TAB   = 4096;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic            in_sel = 1'b0;
    logic [AW-1:0]   in_addr0 = '0;
    logic [AW-1:0]   in_addr1 = '0;
    logic [DW-1:0]   bf_0_upper = '0;
    logic [DW-1:0]   bf_0_lower = '0;
    logic [DW-1:0]   bf_1_upper = '0;
    logic [DW-1:0]   bf_1_lower = '0;
    logic            we;
    logic [AW-1:0]   waddr0;
    logic [AW-1:0]   waddr1;
    logic [2*DW-1:0] wdata0;
    logic [2*DW-1:0] wdata1;
    logic            stage_done;
    logic            busy;

    ntt_writeback #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LAT0(LAT0), .LAT1(LAT1), .PAIRS(PAIRS)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel),
        .in_addr0(in_addr0), .in_addr1(in_addr1),
        .bf_0_upper(bf_0_upper), .bf_0_lower(bf_0_lower),
        .bf_1_upper(bf_1_upper), .bf_1_lower(bf_1_lower),
        .we(we), .waddr0(waddr0), .waddr1(waddr1),
        .wdata0(wdata0), .wdata1(wdata1),
        .stage_done(stage_done), .busy(busy)
    );

    // ---------------- clock / edge counter ----------------
    always #5 clk = ~clk;

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    typedef struct {
        int            due;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [2*DW-1:0] d0;
        logic [2*DW-1:0] d1;
        logic          sd;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   wr_idx = 0;
    logic model_mode = 1'b0;
    int   sd_seen = 0;

    logic [DW-1:0] tab_0u [TAB];
    logic [DW-1:0] tab_0l [TAB];
    logic [DW-1:0] tab_1u [TAB];
    logic [DW-1:0] tab_1l [TAB];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at edge %0d", name, act, req, edge_cnt);
        end
    endtask

    // ---------------- butterfly value driver ----------------
    // Values present before edge k are tab[k], so the model can look them up.
    initial begin
        for (int i = 0; i < TAB; i++) begin
            tab_0u[i] = DW'($urandom);
            tab_0l[i] = DW'($urandom);
            tab_1u[i] = DW'($urandom);
            tab_1l[i] = DW'($urandom);
        end
        forever begin
            bf_0_upper = tab_0u[(edge_cnt + 1) % TAB];
            bf_0_lower = tab_0l[(edge_cnt + 1) % TAB];
            bf_1_upper = tab_1u[(edge_cnt + 1) % TAB];
            bf_1_lower = tab_1l[(edge_cnt + 1) % TAB];
            @(posedge clk);
            #1;
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        exp_t e;
        if (we) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we actual=1 required=0 at edge %0d", edge_cnt);
            end else begin
                e = exp_q.pop_front();
                chk("we_edge", edge_cnt, e.due);
                chk("waddr0", 32'(waddr0), 32'(e.a0));
                chk("waddr1", 32'(waddr1), 32'(e.a1));
                chk("wdata0", 32'(wdata0), 32'(e.d0));
                chk("wdata1", 32'(wdata1), 32'(e.d1));
                chk("stage_done", 32'(stage_done), 32'(e.sd));
            end
        end else begin
            chk("stage_done_idle", 32'(stage_done), 32'd0);
            if (exp_q.size() != 0 && edge_cnt > exp_q[0].due) begin
                checks++;
                failures++;
                $display("FAIL missing_we actual=0 required=1 due edge %0d now %0d",
                         exp_q[0].due, edge_cnt);
                e = exp_q.pop_front();
            end
        end
        if (stage_done) sd_seen++;
        chk("in_ready", 32'(in_ready),
            32'((exp_q.size() == 0) || (in_sel == model_mode)));
        chk("busy", 32'(busy), 32'(exp_q.size() != 0));
    end

    // ---------------- driver tasks (entered and left at posedge+1) ----------------
    task automatic issue(input logic s, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                         output int waits);
        int   t;
        int   lat;
        exp_t e;
        waits    = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_addr0 = a0;
        in_addr1 = a1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waits++;
            if (waits > 20) begin
                checks++;
                failures++;
                $display("FAIL issue_timeout actual=%0d required<=20", waits);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        t   = edge_cnt + 1;
        lat = s ? LAT1 : LAT0;
        @(posedge clk);
        e.due = t + lat;
        e.a0  = a0;
        e.a1  = a1;
        e.d0  = {tab_0u[e.due % TAB], tab_0l[e.due % TAB]};
        e.d1  = {tab_1u[e.due % TAB], tab_1l[e.due % TAB]};
        e.sd  = ((wr_idx % PAIRS) == PAIRS - 1);
        wr_idx++;
        model_mode = s;
        exp_q.push_back(e);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = 1'b0;
        exp_q.delete();
        wr_idx     = 0;
        model_mode = 1'b0;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        @(negedge clk);
        chk("rst_we", 32'(we), 32'd0);
        chk("rst_stage_done", 32'(stage_done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_waddr0", 32'(waddr0), 32'd0);
        chk("rst_waddr1", 32'(waddr1), 32'd0);
        chk("rst_wdata0", 32'(wdata0), 32'd0);
        chk("rst_wdata1", 32'(wdata1), 32'd0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int w;
        int wsum;
        logic s;

        do_reset();

        // Radix-2 latency with fixed butterfly values at the capture edge.
        idle(2);
        tab_0u[(edge_cnt + 1 + LAT0) % TAB] = 12'h123;
        tab_0l[(edge_cnt + 1 + LAT0) % TAB] = 12'h456;
        issue(1'b0, 7'd5, 7'd9, w);
        chk("r2_wait", w, 32'd0);
        wait_drain();
        chk("r2_waddr0", 32'(waddr0), 32'd5);
        chk("r2_waddr1", 32'(waddr1), 32'd9);
        chk("r2_wdata0", 32'(wdata0), 32'h123456);

        // Radix-4 streaming, 8 back-to-back issues.
        wsum = 0;
        for (int i = 0; i < 8; i++) begin
            issue(1'b1, AW'(i), AW'($urandom), w);
            wsum += w;
        end
        chk("r4_stream_stalls", wsum, 32'd0);
        wait_drain();

        // Mode switch: three radix-2 issues, then a radix-4 issue held waiting.
        for (int i = 0; i < 3; i++) begin
            issue(1'b0, AW'(16 + i), AW'(32 + i), w);
        end
        issue(1'b1, 7'd40, 7'd41, w);
        chk("mode_switch_wait", w, LAT0);
        wait_drain();

        // Stage wrap: 130 radix-2 issues from a fresh reset.
        do_reset();
        sd_seen = 0;
        for (int i = 0; i < 130; i++) begin
            issue(1'b0, AW'(i), AW'(~i), w);
        end
        wait_drain();
        chk("stage_done_count", sd_seen, 32'd1);

        // Reset with four radix-4 issues in flight.
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, AW'(60 + i), AW'(70 + i), w);
        end
        do_reset();
        idle(LAT1 + 2);
        issue(1'b1, 7'd99, 7'd100, w);
        chk("post_rst_wait", w, 32'd0);
        wait_drain();

        // Random traffic: occasional mode changes and gaps.
        s = 1'b0;
        for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 7) == 0) s = ~s;
            issue(s, AW'($urandom), AW'($urandom), w);
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
        end
        wait_drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
